note_sequencer: RTL
===================

# note_sequencer

Parametrised beat sequencer and tone generator. It replaces the derived-clock player counter and separate PWM pair in the music path, and runs entirely on `clk` with clock-enable ticks. Keyboard-decoded command pulses drive play, pause, restart, direction, loop and speed. The block emits the current note index to an external tone ROM and converts the returned half-period into a square wave on the audio pin.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency.
- `BASE_BEAT_HZ`, default 1: beat rate at speed level 0.
- `NUM_NOTES`, default 15: sequence length, ≥2.
- `IDX_W`, default 4: note index width; requires 2^IDX_W ≥ NUM_NOTES.
- `SPEED_W`, default 2: speed level width; beat rate is BASE_BEAT_HZ << speed.
- `DIV_W`, default 20: tone half-period width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `play` in 1: one-cycle pulse; start or resume.
- `pause` in 1: one-cycle pulse; freeze.
- `restart` in 1: one-cycle pulse; jump to start position and play.
- `dir` in 1: level; 0 = forward, 1 = reverse.
- `loop` in 1: level; 1 = wrap at end, 0 = stop at end.
- `speed_up` in 1: one-cycle pulse.
- `speed_down` in 1: one-cycle pulse.
- `tone_div` in DIV_W: clk cycles per audio half-period for `beat_idx`; 0 = rest.
- `beat_idx` out IDX_W: current note index.
- `beat_tick` out 1: one-cycle pulse when `beat_idx` advances.
- `done` out 1: one-cycle pulse on non-loop end stop.
- `playing` out 1: high in PLAY.
- `speed` out SPEED_W: current speed level.
- `audio` out 1: square-wave output.

## Operation
- States are STOP, PLAY and PAUSE. Reset enters STOP.
- Command priority per cycle: restart > pause > play.
- restart, from any state:
  - PLAY.
  - `beat_idx` = 0 if dir=0, else NUM_NOTES-1.
  - Beat timer and tone counter cleared.
- pause: PLAY → PAUSE. Index and beat timer are held. Ignored in STOP and PAUSE.
- play:
  - PAUSE → PLAY, resuming the held timer.
  - STOP → PLAY from the current index. If the last stop was an end stop, play starts from the start position instead.
  - Ignored in PLAY.
- Beat timer:
  - Counts in PLAY only.
  - Threshold is T = (CLK_HZ/BASE_BEAT_HZ >> speed) - 1. When the count reaches T, the timer clears and the index steps.
- Step rules:
  - Forward: idx+1; reverse: idx-1.
  - End point: forward at NUM_NOTES-1, reverse at 0.
  - At end point with loop=1: wrap to the opposite endpoint; `beat_tick` pulses.
  - At end point with loop=0: index holds, state → STOP, `done` pulses, no `beat_tick`.
- `dir` is sampled at each step. Changing it mid-beat does not move the index.
- Speed:
  - speed_up saturates at 2^SPEED_W-1; speed_down saturates at 0.
  - Both in the same cycle: no change.
  - An effective change clears the beat timer. A saturated no-op does not.
- Tone generator:
  - In PLAY with tone_div≠0: the half-period counter counts 0..tone_div-1, and `audio` toggles on the wrap.
  - Counter and `audio` clear to 0 on every `beat_idx` change, in STOP and PAUSE, and whenever tone_div=0.
- All outputs are registered.

## Timing
- Reset values:
  - `beat_idx`=0, `speed`=0.
  - `beat_tick`, `done`, `playing`, `audio` all 0.
  - State STOP, all counters 0, end-stop flag 0.
- Command latency: a pulse at edge N is reflected in the state, `playing` and `beat_idx` after edge N+1.
- First step after play or restart: T+1 cycles after `playing` rises.
- `beat_tick` and `done` assert in the same cycle the new index or STOP state is visible.
- Audio period is 2·tone_div cycles. The first toggle occurs tone_div cycles after a counter clear.
- Asserting `rst` mid-beat or mid-tone forces the reset values immediately, with no pending tick.

## Configuration
- `SEQ_PINGPONG_EN` defined:
  - An additional internal direction flip-flop is XORed with `dir`.
  - At an end point with loop=1, the flip-flop toggles and the index steps back inward instead of wrapping. `beat_tick` pulses.
  - The flip-flop clears on restart and reset.
- Undefined: no flip-flop; wrap behaviour as above.

## Test plan
All scenarios use CLK_HZ=1000, BASE_BEAT_HZ=100 (T=9 at speed 0), NUM_NOTES=4, SPEED_W=2.
- Reset, play, dir=0, loop=1 → `beat_idx` 0,1,2,3,0 with a `beat_tick` every 10 cycles; `playing`=1.
- loop=0, dir=1, restart → idx 3,2,1,0. On the next beat: `done` pulse, STOP, idx holds 0. Then play → idx restarts at 3.
- speed_up ×5 → `speed` saturates at 3, T=0, tick every cycle. speed_up and speed_down together → `speed` unchanged.
- Pause 4 cycles into a beat, wait 50 cycles, then play → next tick arrives 6 cycles after resume. `audio`=0 throughout the pause.
- tone_div=3 in PLAY → `audio` period 6 cycles, first rise 3 cycles after index change. tone_div=0 → `audio` stays 0.
- restart and pause in the same cycle → PLAY at idx 0. `rst` asserted mid-beat → all outputs 0 asynchronously. With `SEQ_PINGPONG_EN`: idx 0,1,2,3,2,1,0,1.

Source files
------------

// File: rtl/note_sequencer.sv
// Beat sequencer with STOP/PLAY/PAUSE control, speed levels and a square-wave tone generator.
// Define SEQ_PINGPONG_EN to bounce between the end points instead of wrapping when looping.
module note_sequencer #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BASE_BEAT_HZ = 1,
  parameter int unsigned NUM_NOTES    = 15,
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned SPEED_W      = 2,
  parameter int unsigned DIV_W        = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               play,
  input  logic               pause,
  input  logic               restart,
  input  logic               dir,
  input  logic               loop,
  input  logic               speed_up,
  input  logic               speed_down,
  input  logic [DIV_W-1:0]   tone_div,
  output logic [IDX_W-1:0]   beat_idx,
  output logic               beat_tick,
  output logic               done,
  output logic               playing,
  output logic [SPEED_W-1:0] speed,
  output logic               audio
);

  localparam int unsigned BEAT_CYC = CLK_HZ / BASE_BEAT_HZ;
  localparam int unsigned TMR_W    = (BEAT_CYC > 2) ? $clog2(BEAT_CYC) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_NOTES - 1);
  localparam logic [SPEED_W-1:0] MAX_SPEED = '1;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [TMR_W-1:0]   tmr_q, tmr_d, thr;
  logic [DIV_W-1:0]   tone_q, tone_d;
  logic [IDX_W-1:0]   idx_d, start_idx;
  logic [SPEED_W-1:0] speed_d;
  logic [31:0]        beat_len;
  logic               end_q, end_d;
  logic               tick_d, done_d, audio_d;
  logic               eff_dir, at_end, step, spd_chg;

`ifdef SEQ_PINGPONG_EN
  logic pp_q, pp_d;
`else
  logic pp_q;
  assign pp_q = 1'b0;
`endif

  // Beat threshold shrinks by a power of two per speed level.
  always_comb begin
    beat_len = 32'(BEAT_CYC) >> speed;
    thr      = (beat_len == 32'd0) ? '0 : TMR_W'(beat_len - 32'd1);
  end

  always_comb begin
    eff_dir   = dir ^ pp_q;
    start_idx = eff_dir ? LAST_IDX : '0;
    at_end    = eff_dir ? (beat_idx == '0) : (beat_idx == LAST_IDX);
    spd_chg   = (speed_up ^ speed_down) &&
                (speed_up ? (speed != MAX_SPEED) : (speed != '0));
    step      = (state_q == ST_PLAY) && !restart && !pause && !spd_chg && (tmr_q == thr);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_STOP;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ST_PLAY;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (pause)                      state_d = ST_PAUSE;
          else if (step && at_end && !loop) state_d = ST_STOP;
        end
        ST_PAUSE: if (play) state_d = ST_PLAY;
        default:  state_d = play ? ST_PLAY : ST_STOP;
      endcase
    end
  end

  // Next values of index, timers, speed and output pulses.
  always_comb begin
    idx_d   = beat_idx;
    tmr_d   = tmr_q;
    tone_d  = tone_q;
    audio_d = audio;
    end_d   = end_q;
    speed_d = speed;
    tick_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SEQ_PINGPONG_EN
    pp_d    = pp_q;
`endif

    if (spd_chg) speed_d = speed_up ? speed + SPEED_W'(1) : speed - SPEED_W'(1);

    if (restart) begin
      idx_d = dir ? LAST_IDX : '0;
      tmr_d = '0;
      end_d = 1'b0;
`ifdef SEQ_PINGPONG_EN
      pp_d  = 1'b0;
`endif
    end else if (state_q == ST_STOP && play && end_q) begin
      idx_d = start_idx;
      end_d = 1'b0;
    end else if (step) begin
      tmr_d = '0;
      if (!at_end) begin
        idx_d  = eff_dir ? beat_idx - IDX_W'(1) : beat_idx + IDX_W'(1);
        tick_d = 1'b1;
      end else if (loop) begin
        tick_d = 1'b1;
`ifdef SEQ_PINGPONG_EN
        pp_d   = ~pp_q;
        idx_d  = eff_dir ? IDX_W'(1) : LAST_IDX - IDX_W'(1);
`else
        idx_d  = eff_dir ? LAST_IDX : '0;
`endif
      end else begin
        done_d = 1'b1;
        end_d  = 1'b1;
      end
    end else if (state_q == ST_PLAY && !pause) begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    if (spd_chg) tmr_d = '0;

    // Tone runs only while staying in PLAY on an unchanged, non-rest note.
    if (state_q == ST_PLAY && state_d == ST_PLAY && !restart &&
        idx_d == beat_idx && tone_div != '0) begin
      if (tone_q >= tone_div - DIV_W'(1)) begin
        tone_d  = '0;
        audio_d = ~audio;
      end else begin
        tone_d  = tone_q + DIV_W'(1);
      end
    end else begin
      tone_d  = '0;
      audio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_idx  <= '0;
      tmr_q     <= '0;
      tone_q    <= '0;
      audio     <= 1'b0;
      end_q     <= 1'b0;
      speed     <= '0;
      beat_tick <= 1'b0;
      done      <= 1'b0;
      playing   <= 1'b0;
    end else begin
      beat_idx  <= idx_d;
      tmr_q     <= tmr_d;
      tone_q    <= tone_d;
      audio     <= audio_d;
      end_q     <= end_d;
      speed     <= speed_d;
      beat_tick <= tick_d;
      done      <= done_d;
      playing   <= (state_d == ST_PLAY);
    end
  end

`ifdef SEQ_PINGPONG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pp_q <= 1'b0;
    else     pp_q <= pp_d;
  end
`endif

endmodule
